// File: rtl/lrc_chk.sv
// LRC/XOR checker: packs nibbles MS-first into W-bit words, folds into ACC, compares against a trailing checksum field.
// Latency: ACC updates on the edge taking a word's last nibble; DONE/ERR one cycle after the last checksum nibble. No backpressure: every valid nibble is consumed or dropped.
module lrc_chk #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          CLR_N,
    input  logic          START,
    input  logic          MODE,
    input  logic          NIB_VLD,
    input  logic [3:0]    NIB,
    input  logic          CHK,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic          FRM_ERR,
    output logic [W-1:0]  ACC,
    output logic [CW-1:0] ERR_CNT
);

    localparam int K   = W / 4;
    localparam int NCW = (K > 1) ? $clog2(K) : 1;
    localparam logic [NCW-1:0] NC_LAST = NCW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CSUM,
        S_FIN
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    sr, sr_nxt;
    logic [W-1:0]    rx, rx_nxt;
    logic [W-1:0]    acc, acc_nxt;
    logic [NCW-1:0]  nc, nc_nxt;
    logic            m, m_nxt;
    logic            done, done_nxt;
    logic            err, err_nxt;
    logic            frm_err, frm_err_nxt;
    logic [CW-1:0]   err_cnt, err_cnt_nxt;
    logic [W-1:0]    word;
    logic [W-1:0]    rx_sh;

    // Shifting left by a nibble and dropping the top bits also covers W=4.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] n);
        return (v << 4) | W'(n);
    endfunction

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state   <= S_IDLE;
            sr      <= '0;
            rx      <= '0;
            acc     <= '0;
            nc      <= '0;
            m       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            frm_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            rx      <= rx_nxt;
            acc     <= acc_nxt;
            nc      <= nc_nxt;
            m       <= m_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            frm_err <= frm_err_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        rx_nxt      = rx;
        acc_nxt     = acc;
        nc_nxt      = nc;
        m_nxt       = m;
        done_nxt    = 1'b0;
        err_nxt     = err;
        frm_err_nxt = frm_err;
        err_cnt_nxt = err_cnt;
        word        = shift_in(sr, NIB);
        rx_sh       = shift_in(rx, NIB);

        // The finished record is counted even when a new START lands in FIN.
        if (state == S_FIN) begin
            state_nxt = S_IDLE;
            if ((err || frm_err) && (err_cnt != {CW{1'b1}}))
                err_cnt_nxt = err_cnt + CW'(1);
        end

        if (START) begin
            state_nxt   = S_DATA;
            sr_nxt      = '0;
            rx_nxt      = '0;
            acc_nxt     = '0;
            nc_nxt      = '0;
            m_nxt       = MODE;
            err_nxt     = 1'b0;
            frm_err_nxt = 1'b0;
        end else if (NIB_VLD) begin
            case (state)
                S_DATA: begin
                    if (!CHK) begin
                        sr_nxt = word;
                        if (nc == NC_LAST) begin
                            acc_nxt = m ? (acc ^ word) : (acc - word);
                            nc_nxt  = '0;
                        end else begin
                            nc_nxt = nc + NCW'(1);
                        end
                    end else begin
                        if (nc != '0)
                            frm_err_nxt = 1'b1;
                        sr_nxt = '0;
                        rx_nxt = rx_sh;
                        if (K == 1) begin
                            state_nxt = S_FIN;
                            done_nxt  = 1'b1;
                            err_nxt   = (acc != rx_sh);
                            nc_nxt    = '0;
                        end else begin
                            state_nxt = S_CSUM;
                            nc_nxt    = NCW'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (CHK) begin
                        rx_nxt = rx_sh;
                        if (nc == NC_LAST) begin
                            state_nxt = S_FIN;
                            done_nxt  = 1'b1;
                            err_nxt   = (acc != rx_sh);
                            nc_nxt    = '0;
                        end else begin
                            nc_nxt = nc + NCW'(1);
                        end
                    end else begin
                        frm_err_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY    = (state == S_DATA) || (state == S_CSUM);
    assign DONE    = done;
    assign ERR     = err;
    assign FRM_ERR = frm_err;
    assign ACC     = acc;
    assign ERR_CNT = err_cnt;

endmodule
